// File: rtl/conv_mac_accum_pkg.sv
// Shared widths, q7 limits and the rounding helper for the conv MAC/requantise path.
package conv_mac_accum_pkg;

  localparam int BYTE   = 8;
  localparam int PROD_W = 2 * BYTE;
  localparam int Q7_MIN = -128;
  localparam int Q7_MAX = 127;

  // Half-LSB constant added before an arithmetic right shift by 'shift'
  // (round half up); zero when there is no shift.
  function automatic longint round_bias(input int shift);
    return (shift == 0) ? 64'sd0 : (64'sd1 <<< (shift - 1));
  endfunction

endpackage

// File: rtl/conv_mac_accum_requant.sv
// Combinational requantiser: round, arithmetic shift, clamp to q7, optional ReLU.
module conv_requant
  import conv_mac_accum_pkg::*;
#(
  parameter int ACC_W     = 32,
  parameter int OUT_SHIFT = 9,
  parameter int RELU      = 0
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [BYTE-1:0]  data
);

  // One guard bit so the rounding add cannot wrap at the top of the acc range.
  localparam int RW = ACC_W + 1;
  localparam logic signed [RW-1:0] RND = RW'(round_bias(OUT_SHIFT));
  localparam logic signed [RW-1:0] HI  = RW'(Q7_MAX);
  localparam logic signed [RW-1:0] LO  = RW'(Q7_MIN);

  logic signed [RW-1:0] ext;
  logic signed [RW-1:0] rsum;
  logic signed [RW-1:0] shifted;

  // Round, shift, saturate to q7, then clamp negatives when ReLU is enabled.
  always_comb begin
    ext     = {acc[ACC_W-1], acc};
    rsum    = ext + RND;
    shifted = rsum >>> OUT_SHIFT;
    if (shifted > HI) begin
      data = HI[BYTE-1:0];
    end else if (shifted < LO) begin
      data = LO[BYTE-1:0];
    end else begin
      data = shifted[BYTE-1:0];
    end
    if (RELU != 0 && data[BYTE-1]) begin
      data = '0;
    end
  end

endmodule

// File: rtl/conv_mac_accum.sv
// Three-stage MAC accumulator: product register, saturating accumulate, requantised output.
module conv_mac_accum
  import conv_mac_accum_pkg::*;
#(
  parameter int CONV_DIM_OUT = 32,
  parameter int CONV_OUT_CH  = 32,
  parameter int BIAS_SHIFT   = 0,
  parameter int OUT_SHIFT    = 9,
  parameter int RELU         = 0,
  parameter int ACC_W        = 32,
  parameter int ADDR_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mac_en,
  input  logic                     done,
  input  logic                     fin,
  input  logic signed [BYTE-1:0]   pix,
  input  logic signed [BYTE-1:0]   wgt,
  input  logic signed [BYTE-1:0]   bias,
  input  logic [BYTE-1:0]          idx_i,
  input  logic [BYTE-1:0]          idx_j,
  input  logic [BYTE-1:0]          idx_k,
  output logic                     out_valid,
  output logic signed [BYTE-1:0]   out_data,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     all_done,
  output logic                     acc_sat,
  output logic                     err
);

  // Wide enough for a fully shifted bias plus a product, or the acc plus a product.
  localparam int SUM_W = ((ACC_W > PROD_W + BYTE) ? ACC_W : PROD_W + BYTE) + 2;
  localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  logic signed [PROD_W-1:0] prod1;
  logic                     mac1, start1, done1;
  logic signed [BYTE-1:0]   bias1;
  logic [BYTE-1:0]          i1, j1, k1;
  logic                     open;
  logic                     err_hit;

  logic signed [ACC_W-1:0]  acc;
  logic                     done2;
  logic [BYTE-1:0]          i2, j2, k2;
  logic signed [SUM_W-1:0]  base, addend, sum;
  logic                     sat_hi, sat_lo;
  logic signed [ACC_W-1:0]  acc_next;

  logic signed [BYTE-1:0]   rq;
  logic [ADDR_W-1:0]        addr_c;

  // Protocol errors: done with nothing open, or a new start before the open point closed.
  always_comb begin
    err_hit = (done && !open && !start) || (start && open);
  end

  // Stage 1: register the product and the control/index sidebands; track the open point.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod1  <= '0;
      mac1   <= 1'b0;
      start1 <= 1'b0;
      done1  <= 1'b0;
      bias1  <= '0;
      i1     <= '0;
      j1     <= '0;
      k1     <= '0;
      open   <= 1'b0;
      err    <= 1'b0;
    end else begin
      prod1  <= PROD_W'(pix) * PROD_W'(wgt);
      mac1   <= mac_en;
      start1 <= start;
      done1  <= done;
      if (start) bias1 <= bias;
      if (done) begin
        i1 <= idx_i;
        j1 <= idx_j;
        k1 <= idx_k;
      end
      open <= (open || start) && !done;
      if (err_hit) err <= 1'b1;
    end
  end

  // Seed or accumulate, saturating to the ACC_W range.
  always_comb begin
    base     = start1 ? (SUM_W'(bias1) <<< BIAS_SHIFT) : SUM_W'(acc);
    addend   = mac1 ? SUM_W'(prod1) : '0;
    sum      = base + addend;
    sat_hi   = sum > ACC_MAX;
    sat_lo   = sum < ACC_MIN;
    acc_next = sat_hi ? ACC_MAX[ACC_W-1:0] : (sat_lo ? ACC_MIN[ACC_W-1:0] : sum[ACC_W-1:0]);
  end

  // Stage 2: accumulator update and index hand-over.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      acc_sat <= 1'b0;
      done2   <= 1'b0;
      i2      <= '0;
      j2      <= '0;
      k2      <= '0;
    end else begin
      acc   <= acc_next;
      done2 <= done1;
      i2    <= i1;
      j2    <= j1;
      k2    <= k1;
      if (sat_hi || sat_lo) acc_sat <= 1'b1;
    end
  end

  conv_requant #(
    .ACC_W     (ACC_W),
    .OUT_SHIFT (OUT_SHIFT),
    .RELU      (RELU)
  ) u_requant (
    .acc  (acc),
    .data (rq)
  );

  // HWC address; wraps at ADDR_W by design.
  always_comb begin
    addr_c = (ADDR_W'(j2) * ADDR_W'(CONV_DIM_OUT) + ADDR_W'(k2)) * ADDR_W'(CONV_OUT_CH)
             + ADDR_W'(i2);
  end

  // Stage 3: result register and completion flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      all_done  <= 1'b0;
    end else begin
      out_valid <= done2;
      if (done2) begin
        out_data <= rq;
        out_addr <= addr_c;
      end
      if (fin && !done1 && !done2 && !out_valid) all_done <= 1'b1;
    end
  end

endmodule
